// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem word addressing, and an IF/ID slot
// with valid/ready handshake, branch flush and a sticky bad-PC fault.
module fetch_stage #(
    parameter int             N        = 64,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter int             CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_src_i,
    input  logic [N-1:0]     pc_branch_i,
    input  logic             ready_i,
    output logic [5:0]       imem_addr_o,
    input  logic [31:0]      imem_q_i,
    output logic [31:0]      instr_o,
    output logic [N-1:0]     pc_o,
    output logic             valid_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    typedef enum logic {RUN, FAULT} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [N-1:0]     pco_q, pco_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic pc_bad;
    logic xfer;

    // Only the 64-word ROM window [0x00, 0xFC] with word alignment is fetchable.
    assign pc_bad = (pc_q[1:0] != 2'b00) || (pc_q[N-1:8] != '0);
    assign xfer   = valid_q && ready_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pco_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pco_q   <= pco_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pco_d   = pco_q;
        valid_d = valid_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                // A transfer on this edge counts even when a redirect or fault wins.
                if (xfer) cnt_d = cnt_q + CNT_W'(1);
                if (pc_src_i) begin
                    pc_d    = pc_branch_i;
                    valid_d = 1'b0;
                end else if (pc_bad) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    valid_d = 1'b0;
                end else if (!valid_q || ready_i) begin
                    instr_d = imem_q_i;
                    pco_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + N'(4);
                end
            end
            FAULT: begin
                valid_d = 1'b0;
            end
            default: state_d = FAULT;
        endcase
    end

    assign imem_addr_o = pc_q[7:2];
    assign instr_o     = instr_q;
    assign pc_o        = pco_q;
    assign valid_o     = valid_q;
    assign fault_o     = fault_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// redirect/fault/reset sequences, then randomized traffic against a reference model.
module tb_fetch_stage;

    localparam int N     = 64;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             pc_src_i;
    logic [N-1:0]     pc_branch_i;
    logic             ready_i;
    logic [5:0]       imem_addr_o;
    logic [31:0]      imem_q_i;
    logic [31:0]      instr_o;
    logic [N-1:0]     pc_o;
    logic             valid_o;
    logic             fault_o;
    logic [CNT_W-1:0] fetch_cnt_o;

    logic [31:0] rom [64];

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what decode should be seeing, derived from the fetch rules.
    logic [N-1:0]     m_pc;
    logic             m_valid;
    logic [31:0]      m_instr;
    logic [N-1:0]     m_pco;
    logic             m_fault;
    logic [CNT_W-1:0] m_cnt;

    fetch_stage #(.N(N), .RESET_PC('0), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .pc_src_i(pc_src_i), .pc_branch_i(pc_branch_i),
        .ready_i(ready_i), .imem_addr_o(imem_addr_o), .imem_q_i(imem_q_i),
        .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o), .fault_o(fault_o),
        .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk = ~clk;
    assign imem_q_i = rom[imem_addr_o];

    typedef struct {
        logic         src;
        logic [63:0]  br;
        logic         rdy;
        logic         e_valid;
        logic [31:0]  e_instr;
        logic [63:0]  e_pc;
        logic [15:0]  e_cnt;
        logic [5:0]   e_addr;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = '0; m_valid = 0; m_instr = '0; m_pco = '0; m_fault = 0; m_cnt = '0;
    endfunction

    function automatic void model_step(input logic src, input logic [63:0] br, input logic rdy);
        bit in_window;
        if (m_fault) return;
        in_window = (m_pc % 4 == 0) && (m_pc < 256);
        if (m_valid && rdy) m_cnt = m_cnt + 1;
        if (src) begin
            m_pc = br; m_valid = 0;
        end else if (!in_window) begin
            m_fault = 1; m_valid = 0;
        end else if (!m_valid || rdy) begin
            m_instr = rom[m_pc / 4]; m_pco = m_pc; m_valid = 1; m_pc = m_pc + 4;
        end
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, ".valid"}, 64'(valid_o), 64'(m_valid));
        chk({tag, ".fault"}, 64'(fault_o), 64'(m_fault));
        chk({tag, ".cnt"},   64'(fetch_cnt_o), 64'(m_cnt));
        chk({tag, ".addr"},  64'(imem_addr_o), 64'(m_pc[7:2]));
        if (m_valid) begin
            chk({tag, ".instr"}, 64'(instr_o), 64'(m_instr));
            chk({tag, ".pc_o"},  pc_o, m_pco);
        end
    endtask

    // Inputs are already applied (at the previous falling edge); advance one edge.
    task automatic cyc();
        @(posedge clk);
        model_step(pc_src_i, pc_branch_i, ready_i);
        @(negedge clk);
    endtask

    task automatic drive(input logic src, input logic [63:0] br, input logic rdy);
        pc_src_i = src; pc_branch_i = br; ready_i = rdy;
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst.valid", 64'(valid_o), 0);
        chk("rst.fault", 64'(fault_o), 0);
        chk("rst.instr", 64'(instr_o), 0);
        chk("rst.pc_o",  pc_o, 0);
        chk("rst.cnt",   64'(fetch_cnt_o), 0);
        chk("rst.addr",  64'(imem_addr_o), 0);
        #1 reset = 1'b0;
    endtask

    vec_t vt[10];

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hf800_0000 + 32'(i) * 32'h8001;
        rom[16] = 32'hcb0e_01ce;

        vt[0] = '{0, 0,     1, 1, 32'hf8000000, 64'h00, 0, 6'h01};
        vt[1] = '{0, 0,     1, 1, 32'hf8008001, 64'h04, 1, 6'h02};
        vt[2] = '{0, 0,     1, 1, 32'hf8010002, 64'h08, 2, 6'h03};
        vt[3] = '{0, 0,     0, 1, 32'hf8010002, 64'h08, 2, 6'h03};
        vt[4] = '{0, 0,     0, 1, 32'hf8010002, 64'h08, 2, 6'h03};
        vt[5] = '{0, 0,     0, 1, 32'hf8010002, 64'h08, 2, 6'h03};
        vt[6] = '{0, 0,     1, 1, 32'hf8018003, 64'h0C, 3, 6'h04};
        vt[7] = '{1, 64'h40, 0, 0, 32'hf8018003, 64'h0C, 3, 6'h10};
        vt[8] = '{0, 0,     0, 1, 32'hcb0e01ce, 64'h40, 3, 6'h11};
        vt[9] = '{0, 0,     1, 1, 32'hf8088011, 64'h44, 4, 6'h12};

        reset = 1'b1;
        drive(0, 0, 0);
        model_reset();
        #1;
        chk("init.valid", 64'(valid_o), 0);
        chk("init.addr",  64'(imem_addr_o), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed table: fill, stall, flush under stall, resume.
        foreach (vt[i]) begin
            drive(vt[i].src, vt[i].br, vt[i].rdy);
            cyc();
            chk($sformatf("vec%0d.valid", i), 64'(valid_o), 64'(vt[i].e_valid));
            chk($sformatf("vec%0d.instr", i), 64'(instr_o), 64'(vt[i].e_instr));
            chk($sformatf("vec%0d.pc_o", i),  pc_o, vt[i].e_pc);
            chk($sformatf("vec%0d.cnt", i),   64'(fetch_cnt_o), 64'(vt[i].e_cnt));
            chk($sformatf("vec%0d.addr", i),  64'(imem_addr_o), 64'(vt[i].e_addr));
            chk($sformatf("vec%0d.fault", i), 64'(fault_o), 0);
        end

        // Misaligned branch target: fault on the edge after the redirect, then sticky.
        drive(1, 64'h42, 0); cyc(); chk_model("mis0");
        chk("mis0.fault", 64'(fault_o), 0);
        drive(0, 0, 1); cyc(); chk_model("mis1");
        chk("mis1.fault", 64'(fault_o), 1);
        chk("mis1.valid", 64'(valid_o), 0);
        drive(1, 64'h0, 1); cyc(); chk_model("mis2");
        chk("mis2.addr", 64'(imem_addr_o), 64'h10);
        cyc(); chk_model("mis3");
        async_reset();

        // Last ROM word then fall off the window; the final transfer still counts.
        drive(1, 64'hFC, 1); cyc(); chk_model("end0");
        drive(0, 0, 1); cyc(); chk_model("end1");
        chk("end1.pc_o", pc_o, 64'hFC);
        chk("end1.instr", 64'(instr_o), 64'(rom[63]));
        cyc(); chk_model("end2");
        chk("end2.fault", 64'(fault_o), 1);
        chk("end2.cnt", 64'(fetch_cnt_o), 1);
        cyc(); chk_model("end3");

        // Mid-run async reset, then resume from 0.
        async_reset();
        drive(0, 0, 0); cyc(); chk_model("rs0"); cyc(); chk_model("rs1");
        drive(0, 0, 1); cyc(); chk_model("rs2");
        drive(0, 0, 0); async_reset();
        chk("rs3.valid", 64'(valid_o), 0);
        cyc(); chk_model("rs4");
        chk("rs4.pc_o", pc_o, 0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            logic        src, rdy;
            logic [63:0] br;
            int          r;
            rdy = ($urandom_range(0, 3) != 0);
            src = ($urandom_range(0, 9) == 0);
            r   = $urandom_range(0, 19);
            if (r < 15)       br = 64'($urandom_range(0, 63)) * 4;
            else if (r == 15) br = 64'hFC;
            else if (r == 16) br = 64'($urandom_range(0, 63)) * 4 + 64'($urandom_range(1, 3));
            else if (r == 17) br = 64'h100 + 64'($urandom_range(0, 15)) * 4;
            else              br = {32'($urandom), 32'h0};
            drive(src, br, rdy);
            if ($urandom_range(0, 39) == 0) async_reset();
            cyc();
            chk_model($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
